// File: rtl/ps2_kbd_event_queue_pkg.sv
// Shared types for the PS/2 Set 2 keyboard event path: event record, prefix
// bytes, HID modifier bit positions and decoder states.
package ps2_kbd_pkg;

  typedef struct packed {
    logic       is_release;
    logic       is_extended;
    logic [7:0] code;
  } kbd_event_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_OVR_LO = 8'h00;
  localparam logic [7:0] SC_OVR_HI = 8'hFF;
  localparam logic [7:0] SC_PAUSE  = 8'h77;

  // Bytes that follow E1 before the synthetic Pause event is produced.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam logic [2:0] MOD_LCTRL  = 3'd0;
  localparam logic [2:0] MOD_LSHIFT = 3'd1;
  localparam logic [2:0] MOD_LALT   = 3'd2;
  localparam logic [2:0] MOD_LGUI   = 3'd3;
  localparam logic [2:0] MOD_RCTRL  = 3'd4;
  localparam logic [2:0] MOD_RSHIFT = 3'd5;
  localparam logic [2:0] MOD_RALT   = 3'd6;
  localparam logic [2:0] MOD_RGUI   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } mod_sel_t;

  function automatic logic is_noise_byte(input logic [7:0] code);
    return (code == SC_BAT) || (code == SC_ACK) || (code == SC_RESEND) ||
           (code == SC_OVR_LO) || (code == SC_OVR_HI);
  endfunction

  // Fake-shift codes E0 12 / E0 59 deliberately have no entry here.
  function automatic mod_sel_t mod_lookup(input kbd_event_t ev);
    mod_sel_t sel;
    sel = '{hit: 1'b0, idx: 3'd0};
    if (!ev.is_extended) begin
      case (ev.code)
        8'h14:   sel = '{hit: 1'b1, idx: MOD_LCTRL};
        8'h12:   sel = '{hit: 1'b1, idx: MOD_LSHIFT};
        8'h11:   sel = '{hit: 1'b1, idx: MOD_LALT};
        8'h59:   sel = '{hit: 1'b1, idx: MOD_RSHIFT};
        default: sel = '{hit: 1'b0, idx: 3'd0};
      endcase
    end else begin
      case (ev.code)
        8'h1F:   sel = '{hit: 1'b1, idx: MOD_LGUI};
        8'h14:   sel = '{hit: 1'b1, idx: MOD_RCTRL};
        8'h11:   sel = '{hit: 1'b1, idx: MOD_RALT};
        8'h27:   sel = '{hit: 1'b1, idx: MOD_RGUI};
        default: sel = '{hit: 1'b0, idx: 3'd0};
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/ps2_kbd_event_queue_if.sv
// Scancode input, CPU poll/clear controls and event/status outputs of the
// keyboard event queue; master drives the inputs, slave is the queue.
interface ps2_kbd_event_queue_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
  logic [7:0]       ps2_code_i;
  logic             ps2_strobe_i;
  logic             ps2_err_i;
  logic             rd_i;
  logic             clr_i;
  logic [9:0]       event_o;
  logic             valid_o;
  logic [CNT_W-1:0] level_o;
  logic [7:0]       modifiers_o;
  logic             overflow_o;
  logic             err_o;

  modport master (
    output ps2_code_i, ps2_strobe_i, ps2_err_i, rd_i, clr_i,
    input  event_o, valid_o, level_o, modifiers_o, overflow_o, err_o
  );

  modport slave (
    input  ps2_code_i, ps2_strobe_i, ps2_err_i, rd_i, clr_i,
    output event_o, valid_o, level_o, modifiers_o, overflow_o, err_o
  );
endinterface

// File: rtl/ps2_kbd_event_queue_fifo.sv
// First-word-fall-through synchronous FIFO; read data is the entry under the
// read pointer, occupancy and valid are registered.
module sync_fifo_fwft #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] level,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q, level_q;
  logic [CNT_W-1:0] occ, occ_next;
  logic             valid_q, full, empty, do_push, do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign full     = (occ == CNT_W'(DEPTH));
  assign empty    = (occ == '0);
  assign do_pop   = rd_en && !empty;
  assign do_push  = wr_en && (!full || do_pop);
  assign drop     = wr_en && !do_push;
  assign occ_next = occ + CNT_W'(do_push) - CNT_W'(do_pop);

  // NOTE: the storage array has no reset; only pointers define what is valid,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
      level_q <= occ_next;
      valid_q <= (occ_next != '0);
    end
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign valid   = valid_q;
  assign level   = level_q;
endmodule

// File: rtl/ps2_kbd_event_queue.sv
// PS/2 Set 2 scancode decoder: folds E0/F0/E1 prefix sequences into key
// events, tracks HID modifiers and queues events for CPU polling.
module ps2_kbd_event_queue
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n_i,
  ps2_kbd_event_queue_if.slave bus
);
  dec_state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [7:0] mods_q;
  logic       overflow_q, err_q;
  logic       emit, drop;
  kbd_event_t ev;
  mod_sel_t   sel;

  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    ev      = '0;
    if (bus.ps2_err_i) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end else if (bus.ps2_strobe_i) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ps2_code_i == SC_E0) begin
            state_d = ST_E0;
          end else if (bus.ps2_code_i == SC_F0) begin
            state_d = ST_F0;
          end else if (bus.ps2_code_i == SC_E1) begin
            state_d = ST_PAUSE;
            skip_d  = PAUSE_SKIP;
          end else if (!is_noise_byte(bus.ps2_code_i)) begin
            emit = 1'b1;
            ev   = '{is_release: 1'b0, is_extended: 1'b0, code: bus.ps2_code_i};
          end
        end
        ST_E0: begin
          if (bus.ps2_code_i == SC_F0) begin
            state_d = ST_E0F0;
          end else if (bus.ps2_code_i != SC_E0) begin
            emit    = 1'b1;
            ev      = '{is_release: 1'b0, is_extended: 1'b1, code: bus.ps2_code_i};
            state_d = ST_IDLE;
          end
        end
        ST_F0: begin
          emit    = 1'b1;
          ev      = '{is_release: 1'b1, is_extended: 1'b0, code: bus.ps2_code_i};
          state_d = ST_IDLE;
        end
        ST_E0F0: begin
          emit    = 1'b1;
          ev      = '{is_release: 1'b1, is_extended: 1'b1, code: bus.ps2_code_i};
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          // The whole E1 make/break burst collapses into one extended 77 make.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            emit    = 1'b1;
            ev      = '{is_release: 1'b0, is_extended: 1'b1, code: SC_PAUSE};
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sel = mod_lookup(ev);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      mods_q     <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      if (emit && sel.hit) mods_q[sel.idx] <= !ev.is_release;
      // Set has priority over a same-cycle clear.
      overflow_q <= drop | (overflow_q & ~bus.clr_i);
      err_q      <= bus.ps2_err_i | (err_q & ~bus.clr_i);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n_i),
    .wr_en   (emit),
    .wr_data (ev),
    .rd_en   (bus.rd_i),
    .rd_data (bus.event_o),
    .valid   (bus.valid_o),
    .level   (bus.level_o),
    .drop    (drop)
  );

  assign bus.modifiers_o = mods_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.err_o       = err_q;
endmodule
